// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 move sequencer and its environment.
package game_2048_pkg;

    localparam int TILE_W = 12;

    typedef logic [TILE_W-1:0] tile_t;
    typedef tile_t [3:0][3:0]  board_t;   // [row][col], row 3 is the top row

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b1000;

    // Value of a freshly spawned seed tile.
    localparam tile_t SEED_TILE = tile_t'(2);

    typedef enum logic [2:0] {
        ST_SEED1,
        ST_SEED2,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_COMMIT,
        ST_CHECK,
        ST_OVER
    } seq_state_t;

endpackage

// File: rtl/lfsr_8.sv
// Free-running 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
module lfsr_8 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_seed,
    output logic [7:0] o_q
);

    logic [7:0] r_q;
    logic       w_fb;

    // Taps at stages 8,6,5,4 (bits 7,5,4,3).
    assign w_fb = r_q[7] ^ r_q[5] ^ r_q[4] ^ r_q[3];

    // Shift every cycle; the seed is loaded only by reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= i_seed;
        end else begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/move_sequencer.sv
// Initiator side of the 2048 move-engine handshake: owns the board, turns
// button edges into move requests, commits results and tracks win/lose.
//
// Handshake: o_enable rises one cycle after ISSUE and stays high with
// o_direction/o_rand_pos stable until the engine's i_ready is sampled high
// (i_matrix_d is captured on that same edge). o_enable then stays high for
// the COMMIT cycle and falls, so a request is at least two cycles long.
// Without i_ready for TIMEOUT cycles the request is abandoned.
module move_sequencer
    import game_2048_pkg::*;
#(
    parameter int unsigned WIN_VALUE = 2048,
    parameter int unsigned TIMEOUT   = 64,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_btn,
    input  logic        i_new_game,
    input  board_t      i_matrix_d,
    input  logic        i_ready,
    output logic        o_enable,
    output logic [3:0]  o_direction,
    output logic [3:0]  o_rand_pos,
    output board_t      o_matrix,
    output logic        o_busy,
    output logic        o_won,
    output logic        o_lost,
    output logic        o_timeout_err,
    output logic [15:0] o_move_count,
    output seq_state_t  o_state
);

    localparam int    CNT_W    = $clog2(TIMEOUT + 1);
    localparam tile_t WIN_TILE = tile_t'(WIN_VALUE);

    // Any tile equal to the winning value.
    function automatic logic board_won(input board_t b);
        logic f;
        f = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == WIN_TILE) f = 1'b1;
        return f;
    endfunction

    // Lost when no empty cell and no orthogonally adjacent equal pair exist.
    function automatic logic board_lost(input board_t b);
        logic can_move;
        can_move = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == '0) can_move = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (b[r][c] == b[r][c+1]) can_move = 1'b1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == b[r+1][c]) can_move = 1'b1;
        return !can_move;
    endfunction

    seq_state_t       r_state, w_state_nxt;
    board_t           r_board, w_board_nxt;
    board_t           r_result, w_result_nxt;
    logic             r_enable, w_enable_nxt;
    logic [3:0]       r_direction, w_direction_nxt;
    logic [3:0]       r_rand_pos, w_rand_pos_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_won, w_won_nxt;
    logic             r_lost, w_lost_nxt;
    logic             r_timeout_err, w_timeout_err_nxt;
    logic [15:0]      r_move_count, w_move_count_nxt;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [3:0]       r_btn_q, r_btn_qq;

    logic [7:0]       w_lfsr;
    logic [3:0]       w_lfsr_unused;
    logic [3:0]       w_pos;
    logic [3:0]       w_rise;
    logic             w_rise_valid;
    logic             w_won, w_lost;

    lfsr_8 u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_seed (LFSR_SEED),
        .o_q    (w_lfsr)
    );

    assign w_pos         = w_lfsr[3:0];
    assign w_lfsr_unused = w_lfsr[7:4];
    assign w_rise        = r_btn_q & ~r_btn_qq;
    assign w_rise_valid  = $onehot(w_rise);
    assign w_won         = board_won(r_board);
    assign w_lost        = board_lost(r_board);

    // Two-stage button register: first stage samples, second gives the edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btn_q  <= '0;
            r_btn_qq <= '0;
        end else begin
            r_btn_q  <= i_btn;
            r_btn_qq <= r_btn_q;
        end
    end

    // State and registered-output update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_SEED1;
            r_board       <= '0;
            r_result      <= '0;
            r_enable      <= 1'b0;
            r_direction   <= '0;
            r_rand_pos    <= LFSR_SEED[3:0];
            r_busy        <= 1'b0;
            r_won         <= 1'b0;
            r_lost        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_move_count  <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_board       <= w_board_nxt;
            r_result      <= w_result_nxt;
            r_enable      <= w_enable_nxt;
            r_direction   <= w_direction_nxt;
            r_rand_pos    <= w_rand_pos_nxt;
            r_busy        <= w_busy_nxt;
            r_won         <= w_won_nxt;
            r_lost        <= w_lost_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_move_count  <= w_move_count_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    // Next-state and next-output logic; new_game overrides every state.
    always_comb begin
        w_state_nxt       = r_state;
        w_board_nxt       = r_board;
        w_result_nxt      = r_result;
        w_enable_nxt      = r_enable;
        w_direction_nxt   = r_direction;
        w_rand_pos_nxt    = r_rand_pos;
        w_won_nxt         = r_won;
        w_lost_nxt        = r_lost;
        w_timeout_err_nxt = r_timeout_err;
        w_move_count_nxt  = r_move_count;
        w_wait_cnt_nxt    = r_wait_cnt;

        if (i_new_game) begin
            w_state_nxt       = ST_SEED1;
            w_board_nxt       = '0;
            w_enable_nxt      = 1'b0;
            w_won_nxt         = 1'b0;
            w_lost_nxt        = 1'b0;
            w_timeout_err_nxt = 1'b0;
            w_move_count_nxt  = '0;
        end else begin
            case (r_state)
                ST_SEED1: begin
                    w_board_nxt[w_pos[3:2]][w_pos[1:0]] = SEED_TILE;
                    w_state_nxt = ST_SEED2;
                end
                ST_SEED2: begin
                    // Retry each cycle until the LFSR points at an empty cell.
                    if (r_board[w_pos[3:2]][w_pos[1:0]] == '0) begin
                        w_board_nxt[w_pos[3:2]][w_pos[1:0]] = SEED_TILE;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_rise_valid) begin
                        w_direction_nxt   = w_rise;
                        w_rand_pos_nxt    = w_pos;
                        w_timeout_err_nxt = 1'b0;
                        w_state_nxt       = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    w_enable_nxt   = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_ready) begin
                        w_result_nxt = i_matrix_d;
                        w_state_nxt  = ST_COMMIT;
                    end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        w_timeout_err_nxt = 1'b1;
                        w_enable_nxt      = 1'b0;
                        w_state_nxt       = ST_IDLE;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    w_enable_nxt = 1'b0;
                    // A move that changes nothing is not counted.
                    if (r_result != r_board) begin
                        w_board_nxt = r_result;
                        if (r_move_count != 16'hFFFF)
                            w_move_count_nxt = r_move_count + 16'd1;
                    end
                    w_state_nxt = ST_CHECK;
                end
                ST_CHECK: begin
                    w_won_nxt   = w_won;
                    w_lost_nxt  = w_lost;
                    w_state_nxt = (w_won || w_lost) ? ST_OVER : ST_IDLE;
                end
                ST_OVER: begin
                    w_state_nxt = ST_OVER;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        w_busy_nxt = !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_OVER));
    end

    assign o_enable      = r_enable;
    assign o_direction   = r_direction;
    assign o_rand_pos    = r_rand_pos;
    assign o_matrix      = r_board;
    assign o_busy        = r_busy;
    assign o_won         = r_won;
    assign o_lost        = r_lost;
    assign o_timeout_err = r_timeout_err;
    assign o_move_count  = r_move_count;
    assign o_state       = r_state;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a small move-engine responder.
module tb_move_sequencer;
    import game_2048_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  i_btn;
    logic        i_new_game;
    board_t      i_matrix_d;
    logic        i_ready;
    logic        o_enable;
    logic [3:0]  o_direction;
    logic [3:0]  o_rand_pos;
    board_t      o_matrix;
    logic        o_busy;
    logic        o_won;
    logic        o_lost;
    logic        o_timeout_err;
    logic [15:0] o_move_count;
    seq_state_t  o_state;

    int total;
    int bad;

    move_sequencer #(
        .WIN_VALUE (2048),
        .TIMEOUT   (64),
        .LFSR_SEED (8'hA5)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_btn         (i_btn),
        .i_new_game    (i_new_game),
        .i_matrix_d    (i_matrix_d),
        .i_ready       (i_ready),
        .o_enable      (o_enable),
        .o_direction   (o_direction),
        .o_rand_pos    (o_rand_pos),
        .o_matrix      (o_matrix),
        .o_busy        (o_busy),
        .o_won         (o_won),
        .o_lost        (o_lost),
        .o_timeout_err (o_timeout_err),
        .o_move_count  (o_move_count),
        .o_state       (o_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_val(input board_t b, input tile_t v);
        int n;
        n = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (b[r][c] == v) n++;
        return n;
    endfunction

    // Wait (bounded) for the sequencer to reach IDLE.
    task automatic wait_idle(output int ok);
        int guard;
        guard = 0;
        while (o_state !== ST_IDLE && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        ok = (o_state === ST_IDLE) ? 1 : 0;
    endtask

    // Freshly seeded board: two 2-tiles, fourteen empty cells.
    task automatic check_seeded(input string tag);
        check({tag, "_twos"},  256'(count_val(o_matrix, tile_t'(2))), 256'(2));
        check({tag, "_zeros"}, 256'(count_val(o_matrix, tile_t'(0))), 256'(14));
    endtask

    // Press dir, act as engine: raise ready in enable cycle rdy_at (0 = never).
    task automatic run_move(input logic [3:0] dir, input logic [3:0] busy_btn,
                            input board_t res, input int rdy_at,
                            output int en_cycles, output int dir_bad);
        int guard;
        en_cycles = 0;
        dir_bad   = 0;
        i_btn     = dir;
        guard     = 0;
        while (!o_enable && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        while (o_enable && en_cycles < 200) begin
            en_cycles++;
            if (o_direction !== dir) dir_bad++;
            if (en_cycles == 1) i_btn = busy_btn;
            if (en_cycles == rdy_at) begin
                i_ready    = 1'b1;
                i_matrix_d = res;
            end else begin
                i_ready = 1'b0;
            end
            @(negedge clk);
        end
        i_ready = 1'b0;
    endtask

    // Hold btn for n cycles and count cycles with enable high.
    task automatic idle_window(input logic [3:0] btn, input int n, output int en_seen);
        en_seen = 0;
        i_btn   = btn;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_enable) en_seen++;
        end
    endtask

    task automatic release_btn();
        i_btn = 4'b0000;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        board_t b1, b2, b_win, b_alt, b_pair;
        int     en, dbad, ok, guard;

        total = 0;
        bad   = 0;

        b1 = '0;  b1[0][0] = 12'd4;  b1[0][1] = 12'd2;
        b2 = '0;  b2[0][0] = 12'd8;  b2[1][0] = 12'd2;
        b_win = '0; b_win[2][3] = 12'd2048; b_win[0][0] = 12'd2;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                b_alt[r][c] = (((r + c) % 2) == 1) ? 12'd4 : 12'd2;
        b_pair = b_alt;
        b_pair[3][3] = 12'd4;   // pairs with b_pair[3][2]

        // Reset
        rst        = 1'b1;
        i_btn      = 4'b0000;
        i_new_game = 1'b0;
        i_matrix_d = '0;
        i_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_enable",  256'(o_enable), 256'(0));
        check("rst_busy",    256'(o_busy), 256'(0));
        check("rst_count",   256'(o_move_count), 256'(0));
        check("rst_randpos", 256'(o_rand_pos), 256'(4'h5));
        check("rst_flags",   256'({o_won, o_lost, o_timeout_err}), 256'(0));
        check("rst_board",   256'(o_matrix), 256'(0));
        check("rst_state",   256'(o_state), 256'(ST_SEED1));
        rst = 1'b0;
        wait_idle(ok);
        check("seed_idle", 256'(ok), 256'(1));
        check_seeded("seed");
        check("seed_enable", 256'(o_enable), 256'(0));

        // Normal move, ready in third enable cycle
        run_move(DIR_RIGHT, DIR_RIGHT, b1, 3, en, dbad);
        check("mv1_en_cycles", 256'(en), 256'(4));
        check("mv1_dir",       256'(dbad), 256'(0));
        repeat (2) @(negedge clk);
        check("mv1_board", 256'(o_matrix), 256'(b1));
        check("mv1_count", 256'(o_move_count), 256'(1));
        check("mv1_state", 256'(o_state), 256'(ST_IDLE));
        check("mv1_flags", 256'({o_won, o_lost}), 256'(0));
        release_btn();

        // Two simultaneous edges: no request
        idle_window(4'b0011, 12, en);
        check("two_btn_en",    256'(en), 256'(0));
        check("two_btn_state", 256'(o_state), 256'(ST_IDLE));
        release_btn();

        // New edge on DOWN while busy is dropped
        run_move(DIR_RIGHT, 4'b0101, b2, 3, en, dbad);
        check("busy_en_cycles", 256'(en), 256'(4));
        check("busy_dir",       256'(dbad), 256'(0));
        idle_window(4'b0101, 12, en);
        check("busy_no_second", 256'(en), 256'(0));
        check("busy_board",     256'(o_matrix), 256'(b2));
        check("busy_count",     256'(o_move_count), 256'(2));
        release_btn();

        // Engine returns an unchanged board: not counted
        run_move(DIR_UP, DIR_UP, b2, 3, en, dbad);
        check("same_en_cycles", 256'(en), 256'(4));
        repeat (2) @(negedge clk);
        check("same_count", 256'(o_move_count), 256'(2));
        check("same_board", 256'(o_matrix), 256'(b2));
        release_btn();

        // Engine never answers: timeout
        run_move(DIR_LEFT, DIR_LEFT, b1, 0, en, dbad);
        check("to_en_cycles", 256'(en), 256'(64));
        check("to_err",       256'(o_timeout_err), 256'(1));
        check("to_enable",    256'(o_enable), 256'(0));
        check("to_state",     256'(o_state), 256'(ST_IDLE));
        check("to_board",     256'(o_matrix), 256'(b2));
        check("to_count",     256'(o_move_count), 256'(2));
        release_btn();

        // Ready in first WAIT cycle; full board with one pair is not lost
        run_move(DIR_DOWN, DIR_DOWN, b_pair, 1, en, dbad);
        check("pair_en_cycles", 256'(en), 256'(2));
        repeat (2) @(negedge clk);
        check("pair_to_clear", 256'(o_timeout_err), 256'(0));
        check("pair_flags",    256'({o_won, o_lost}), 256'(0));
        check("pair_state",    256'(o_state), 256'(ST_IDLE));
        check("pair_count",    256'(o_move_count), 256'(3));
        release_btn();

        // Alternating 2/4 full board: lost
        run_move(DIR_UP, DIR_UP, b_alt, 3, en, dbad);
        repeat (2) @(negedge clk);
        check("lost_flags", 256'({o_won, o_lost}), 256'(2'b01));
        check("lost_state", 256'(o_state), 256'(ST_OVER));
        check("lost_busy",  256'(o_busy), 256'(0));
        check("lost_count", 256'(o_move_count), 256'(4));
        release_btn();
        idle_window(DIR_RIGHT, 12, en);
        check("over_no_req", 256'(en), 256'(0));
        check("over_state",  256'(o_state), 256'(ST_OVER));
        check("over_board",  256'(o_matrix), 256'(b_alt));

        // new_game from OVER
        i_new_game = 1'b1;
        @(negedge clk);
        i_new_game = 1'b0;
        check("ng1_state", 256'(o_state), 256'(ST_SEED1));
        check("ng1_board", 256'(o_matrix), 256'(0));
        check("ng1_clear", 256'({o_won, o_lost, o_move_count}), 256'(0));
        i_btn = 4'b0000;
        wait_idle(ok);
        check("ng1_idle", 256'(ok), 256'(1));
        check_seeded("ng1");

        // Win
        run_move(DIR_RIGHT, DIR_RIGHT, b_win, 2, en, dbad);
        check("win_en_cycles", 256'(en), 256'(3));
        repeat (2) @(negedge clk);
        check("win_flags", 256'({o_won, o_lost}), 256'(2'b10));
        check("win_state", 256'(o_state), 256'(ST_OVER));
        check("win_count", 256'(o_move_count), 256'(1));
        release_btn();
        idle_window(DIR_LEFT, 12, en);
        check("win_no_req", 256'(en), 256'(0));
        check("win_board",  256'(o_matrix), 256'(b_win));

        i_new_game = 1'b1;
        @(negedge clk);
        i_new_game = 1'b0;
        i_btn = 4'b0000;
        wait_idle(ok);
        check("ng2_idle", 256'(ok), 256'(1));

        // One committed move, then new_game in the middle of WAIT
        run_move(DIR_LEFT, DIR_LEFT, b1, 3, en, dbad);
        repeat (2) @(negedge clk);
        check("pre_ng_count", 256'(o_move_count), 256'(1));
        release_btn();
        i_btn = DIR_DOWN;
        guard = 0;
        while (!o_enable && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ngw_enable_seen", 256'(o_enable), 256'(1));
        @(negedge clk);
        check("ngw_busy",  256'(o_busy), 256'(1));
        check("ngw_state", 256'(o_state), 256'(ST_WAIT));
        i_new_game = 1'b1;
        @(negedge clk);
        i_new_game = 1'b0;
        check("ngw_enable_drop", 256'(o_enable), 256'(0));
        check("ngw_count",       256'(o_move_count), 256'(0));
        check("ngw_flags",       256'({o_won, o_lost, o_timeout_err}), 256'(0));
        check("ngw_state_seed",  256'(o_state), 256'(ST_SEED1));
        wait_idle(ok);
        check("ngw_idle", 256'(ok), 256'(1));
        check_seeded("ngw");
        release_btn();

        // Asynchronous reset mid-handshake
        i_btn = DIR_UP;
        guard = 0;
        while (!o_enable && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("arst_enable_seen", 256'(o_enable), 256'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_enable",  256'(o_enable), 256'(0));
        check("arst_state",   256'(o_state), 256'(ST_SEED1));
        check("arst_board",   256'(o_matrix), 256'(0));
        check("arst_randpos", 256'(o_rand_pos), 256'(4'h5));
        check("arst_dir",     256'(o_direction), 256'(0));
        @(negedge clk);
        rst   = 1'b0;
        i_btn = 4'b0000;
        wait_idle(ok);
        check("arst_idle", 256'(ok), 256'(1));
        check_seeded("arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Initiator side of the move-engine handshake in the 2048 game. Owns the registered 4×4 board, turns player button presses into one-hot `direction` + `enable` requests to the move engine, and waits for `ready`. It then commits `matrix_D` back into the board and evaluates win/lose status. It sits between the debounced button inputs and the move engine, and feeds the board to the display path.

## Interface
Parameters:
- `TILE_W`, 12: tile value width in bits.
- `WIN_VALUE`, 2048: tile value that declares a win.
- `TIMEOUT`, 64: maximum number of cycles to wait for `ready` before aborting the request.
- `LFSR_SEED`, 8'hA5: value loaded into the LFSR at reset; must be non-zero.

Ports (all outputs registered):
- `clk`  in  1  system clock, single domain.
- `rst`  in  1  reset, **asynchronous, active-high**.
- `btn`  in  4  debounced button levels, one-hot encoded: bit0 right, bit1 left, bit2 down, bit3 up.
- `new_game`  in  1  synchronous restart request.
- `matrix_D`  in  4×4×`TILE_W`  result board from the move engine.
- `ready`  in  1  move engine reports that `matrix_D` is valid.
- `enable`  out  1  move request to the engine.
- `direction`  out  4  one-hot move direction.
- `rand_pos`  out  4  new-tile position hint for the engine.
- `matrix`  out  4×4×`TILE_W`  current board; index `[row][col]`, with `[3][*]` as the top row.
- `busy`  out  1  high whenever the state is not IDLE or OVER.
- `won`, `lost`, `timeout_err`  out  1 each  status flags.
- `move_count`  out  16  number of committed moves.

## Operation
- States: SEED1, SEED2, IDLE, ISSUE, WAIT, COMMIT, CHECK, OVER.
- Reset values:
  - board all zero; state SEED1.
  - `enable`, `direction`, `busy`, `won`, `lost`, `timeout_err` = 0.
  - `move_count` = 0; `rand_pos` = `LFSR_SEED[3:0]`.
- SEED1: write tile 2 at `lfsr[3:0]`, then go to SEED2.
- SEED2: write tile 2 at `lfsr[3:0]` if that cell is zero, then go to IDLE. If the cell is occupied, stay in SEED2; the LFSR advances every cycle.
- IDLE: the edge detector registers `btn`.
  - Proceed only when exactly one bit has a rising edge; otherwise do nothing.
  - On a valid edge: latch `direction` = that bit and `rand_pos` = `lfsr[3:0]`, then go to ISSUE.
- ISSUE: assert `enable`, go to WAIT. Clear `timeout_err` on entry.
- WAIT: hold `enable`, `direction` and `rand_pos` stable.
  - First cycle with `ready` = 1: go to COMMIT.
  - If the wait counter reaches `TIMEOUT` first: set `timeout_err`, drop `enable`, return to IDLE; board unchanged.
- COMMIT: drop `enable`.
  - If `matrix_D` differs from the board: load the board from `matrix_D` and increment `move_count`, saturating at 16'hFFFF.
  - If they are equal: no load, no count.
  - Go to CHECK.
- CHECK:
  - `won` = any tile equal to `WIN_VALUE`.
  - `lost` = no zero tile and no horizontally or vertically adjacent equal pair.
  - If either flag is set, go to OVER; otherwise go to IDLE.
- OVER: ignore buttons; flags and board hold.
- `new_game` has priority in every state:
  - next cycle: clear board, flags and `move_count`, drop `enable`, enter SEED1.
  - the LFSR is not reseeded.
- Buttons pressed while `busy` are dropped, not queued.
- `rst` asserted mid-handshake: `enable` falls asynchronously and all outputs take their reset values.

## Timing
- Rising edge of `btn` visible at clock edge N:
  - N+1: ISSUE.
  - N+2: `enable` = 1.
- `ready` sampled high at edge M:
  - M+1: `enable` = 0 and board updated (COMMIT).
  - M+2: `won`/`lost` valid (CHECK).
- `ready` may already be high at the first WAIT cycle; the minimum request length is then 2 cycles with `enable` high.
- LFSR: 8-bit, polynomial x^8+x^6+x^5+x^4+1, free-running.

## Structure
- Package `game_2048_pkg` holds:
  - `tile_t` (logic [`TILE_W`-1:0]) and `board_t` (tile_t [3:0][3:0]).
  - direction constants `DIR_RIGHT` = 4'b0001, `DIR_LEFT` = 4'b0010, `DIR_DOWN` = 4'b0100, `DIR_UP` = 4'b1000.
  - the state enum `seq_state_t`.
- One sub-module, `lfsr_8` (clk, rst, seed, q). Win/lose detection stays inline as a combinational function.

## Test plan
- Reset → exactly two tiles of value 2 on the board at distinct positions, all others 0, state IDLE, `enable` = 0, `move_count` = 0.
- `btn` = 4'b0001 edge, engine model returns a changed board with `ready` after 3 cycles → `enable` high for 4 cycles, `direction` = 0001 throughout, `matrix` = model board, `move_count` = 1.
- `btn` = 4'b0011 edge (two directions) → no `enable`, stays IDLE. Press while `busy` → ignored, no second request.
- Engine never raises `ready` → `timeout_err` = 1 after 64 WAIT cycles, `enable` = 0, board unchanged.
- Engine returns a board containing 2048 → `won` = 1, OVER, buttons ignored. A full board with no adjacent equal pair (e.g. alternating 2/4) → `lost` = 1.
- `new_game` asserted during WAIT → `enable` drops next cycle, flags and `move_count` cleared, board reseeded with two 2-tiles.
